// File: rtl/wimax_pkg.sv
`default_nettype none
// ============================================================================
// Module : wimax_pkg
// Brief  : Shared block size and serializer state encoding for the WiMAX PHY.
// Rev    : 1.0
// ============================================================================
package wimax_pkg;

   localparam int WIMAX_BLOCK_BITS = 96;

   typedef enum logic [1:0] {
      SER_IDLE  = 2'd0,
      SER_SHIFT = 2'd1,
      SER_GAP   = 2'd2
   } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/wimax_block_serializer_if.sv
`default_nettype none
// ============================================================================
// Module : wimax_block_serializer_if
// Brief  : Block-word input stream and serial-bit output stream of the serializer.
// Rev    : 1.0
// ============================================================================
interface wimax_block_serializer_if #(
   parameter int BLOCK_BITS = wimax_pkg::WIMAX_BLOCK_BITS
);

   logic [BLOCK_BITS-1:0] blk_data;
   logic                  blk_valid;
   logic                  blk_ready;
   logic                  bit_out;
   logic                  bit_valid;
   logic                  bit_ready;

   // master = block source / bit sink, slave = serializer
   modport master (
      output blk_data, blk_valid, bit_ready,
      input  blk_ready, bit_out, bit_valid
   );

   modport slave (
      input  blk_data, blk_valid, bit_ready,
      output blk_ready, bit_out, bit_valid
   );

endinterface
`default_nettype wire

// File: rtl/blk_fifo.sv
`default_nettype none
// ============================================================================
// Module : blk_fifo
// Brief  : Generic synchronous FIFO with first-word fall-through read and flush.
// Rev    : 1.0
// ============================================================================
module blk_fifo #(
   parameter int WIDTH = 96,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_wr_data,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CNT_W = $clog2(DEPTH + 1);
   localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic               w_push;
   logic               w_pop;

   assign o_full    = (r_count == c_DEPTH);
   assign o_empty   = (r_count == '0);
   assign o_rd_data = r_mem[r_rd_ptr];

   // flush wins over both ports; pointers wrap naturally since DEPTH is a power of 2
   assign w_push = i_push && !o_full  && !i_flush;
   assign w_pop  = i_pop  && !o_empty && !i_flush;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/wimax_block_serializer.sv
`default_nettype none
// ============================================================================
// Module : wimax_block_serializer
// Brief  : Buffers 96-bit blocks and emits them MSB-first with an idle gap.
// Rev    : 1.0
// ============================================================================
module wimax_block_serializer
   import wimax_pkg::*;
#(
   parameter int BLOCK_BITS = WIMAX_BLOCK_BITS,
   parameter int FIFO_DEPTH = 2,
   parameter int GAP_CYCLES = 1
) (
   input  logic                     clk_ref,
   input  logic                     rst,
   input  logic                     flush,
   wimax_block_serializer_if.slave  bus,
   output logic                     busy,
   output logic                     block_done,
   output logic [15:0]              blocks_sent
);

   localparam int c_CNT_W = $clog2(BLOCK_BITS);
   localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(BLOCK_BITS - 1);
   localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   ser_state_t              r_state;
   ser_state_t              w_next_state;
   logic [BLOCK_BITS-1:0]   r_shreg;
   logic [c_CNT_W-1:0]      r_bit_cnt;
   logic [c_GAP_W-1:0]      r_gap_cnt;
   logic                    r_done;
   logic [15:0]             r_blocks_sent;
   logic                    r_avail;
   logic [BLOCK_BITS-1:0]   w_head;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_load;
   logic                    w_shift;
   logic                    w_last;
   logic                    w_xfer;

   blk_fifo #(
      .WIDTH (BLOCK_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_ref),
      .rst       (rst),
      .i_flush   (flush),
      .i_push    (w_push),
      .i_pop     (w_pop),
      .i_wr_data (bus.blk_data),
      .o_rd_data (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   assign bus.blk_ready = !w_full;
   assign w_push        = bus.blk_valid && !w_full;
   assign bus.bit_valid = (r_state == SER_SHIFT);
   assign bus.bit_out   = (r_state == SER_SHIFT) && r_shreg[BLOCK_BITS-1];
   assign w_xfer        = (r_state == SER_SHIFT) && bus.bit_ready;
   assign busy          = (r_state != SER_IDLE) || !w_empty;
   assign block_done    = r_done;
   assign blocks_sent   = r_blocks_sent;

   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      w_load       = 1'b0;
      w_shift      = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         // launch waits on the registered not-empty flag, giving a fresh
         // word one full cycle in the FIFO before it is taken
         SER_IDLE: begin
            if (r_avail && !w_empty) begin
               w_pop        = 1'b1;
               w_load       = 1'b1;
               w_next_state = SER_SHIFT;
            end
         end
         SER_SHIFT: begin
            if (w_xfer) begin
               if (r_bit_cnt == c_LAST_BIT) begin
                  w_last = 1'b1;
                  if (GAP_CYCLES > 0) begin
                     w_next_state = SER_GAP;
                  end else if (!w_empty) begin
                     w_pop  = 1'b1;
                     w_load = 1'b1;
                  end else begin
                     w_next_state = SER_IDLE;
                  end
               end else begin
                  w_shift = 1'b1;
               end
            end
         end
         SER_GAP: begin
            if (r_gap_cnt == c_GAP_LAST) begin
               w_next_state = SER_IDLE;
            end
         end
         default: w_next_state = SER_IDLE;
      endcase
      if (flush) begin
         w_next_state = SER_IDLE;
         w_pop        = 1'b0;
         w_load       = 1'b0;
         w_shift      = 1'b0;
         w_last       = 1'b0;
      end
   end

   always_ff @(posedge clk_ref or posedge rst) begin
      if (rst) begin
         r_state       <= SER_IDLE;
         r_shreg       <= '0;
         r_bit_cnt     <= '0;
         r_gap_cnt     <= '0;
         r_done        <= 1'b0;
         r_blocks_sent <= '0;
         r_avail       <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_avail <= !w_empty && !flush;
         r_done  <= w_last;
         if (w_last) begin
            r_blocks_sent <= r_blocks_sent + 16'd1;
         end
         if (w_load) begin
            r_shreg   <= w_head;
            r_bit_cnt <= '0;
         end else if (w_shift) begin
            r_shreg   <= {r_shreg[BLOCK_BITS-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
         end
         if (r_state == SER_GAP) begin
            r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
         end else begin
            r_gap_cnt <= '0;
         end
      end
   end

endmodule
`default_nettype wire
